// File: rtl/ram_dp_be.sv
// ram_dp_be: dual-port RAM, port 0 read/write with byte enables, port 1 read-only,
// selectable read latency and collision policy, optional zeroing sweep after reset.
module ram_dp_be #(
   parameter int DataWidth = 32,
   parameter int NPos = 1024,
   parameter int ReadLatency = 1,
   parameter int WriteFirst = 0,
   parameter int ClearOnReset = 1,
   localparam int NBytes = DataWidth / 8,
   localparam int NPosWidth = $clog2(NPos)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NPosWidth-1:0] a0_i,
   input  logic                 we0_i,
   input  logic [NBytes-1:0]    be0_i,
   input  logic [DataWidth-1:0] wd0_i,
   output logic [DataWidth-1:0] rd0_o,
   input  logic [NPosWidth-1:0] a1_i,
   output logic [DataWidth-1:0] rd1_o,
   output logic                 busy_o
);
   typedef enum logic {CLEAR, IDLE} state_t;
   state_t state, state_d;
   logic [NPosWidth-1:0] cnt, cnt_d;
   logic [DataWidth-1:0] mem [NPos];
   logic [DataWidth-1:0] merged;
   logic busy;
   assign busy = rst_i | (state == CLEAR);
   assign busy_o = busy;
   always_comb begin
      state_d = state;
      cnt_d = cnt;
      if (state == CLEAR) begin
         cnt_d = cnt + NPosWidth'(1);
         if (cnt == NPosWidth'(NPos - 1)) state_d = IDLE;
      end
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= ClearOnReset != 0 ? CLEAR : IDLE;
         cnt <= '0;
      end else begin
         state <= state_d;
         cnt <= cnt_d;
      end
   end
   // Word as it will look after the write: enabled bytes replaced, others kept.
   always_comb begin
      merged = mem[a0_i];
      for (int k = 0; k < NBytes; k++)
         if (be0_i[k]) merged[8*k +: 8] = wd0_i[8*k +: 8];
   end
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (state == CLEAR) mem[cnt] <= '0;
         else if (we0_i) mem[a0_i] <= merged;
      end
   end
   if (ReadLatency == 0) begin : g_async
      assign rd0_o = busy ? '0 : mem[a0_i];
      assign rd1_o = busy ? '0 : mem[a1_i];
   end else begin : g_sync
      always_ff @(posedge clk_i) begin
         rd0_o <= busy ? '0 : (WriteFirst != 0 && we0_i) ? merged : mem[a0_i];
         rd1_o <= busy ? '0 : (WriteFirst != 0 && we0_i && a1_i == a0_i) ? merged : mem[a1_i];
      end
   end
endmodule

// File: tb/tb_ram_dp_be.sv
// tb_ram_dp_be: scoreboard bench over four parameterisations sharing one stimulus stream.
module tb_ram_dp_be;
  logic clk = 0, rst;
  logic [9:0] a0, a1;
  logic we0;
  logic [3:0] be0;
  logic [31:0] wd0;
  logic [31:0] d_rd0, d_rd1, w_rd0, w_rd1, z_rd0, z_rd1, n_rd0, n_rd1;
  logic d_busy, w_busy, z_busy, n_busy;
  int cyc = 0, tests = 0, fails = 0, s;
  typedef struct {int due; int sel; logic [31:0] v; string nm;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  ram_dp_be #(.ReadLatency(1), .WriteFirst(0), .ClearOnReset(1)) u_d (
    .clk_i(clk), .rst_i(rst), .a0_i(a0), .we0_i(we0), .be0_i(be0), .wd0_i(wd0),
    .rd0_o(d_rd0), .a1_i(a1), .rd1_o(d_rd1), .busy_o(d_busy));
  ram_dp_be #(.ReadLatency(1), .WriteFirst(1), .ClearOnReset(1)) u_w (
    .clk_i(clk), .rst_i(rst), .a0_i(a0), .we0_i(we0), .be0_i(be0), .wd0_i(wd0),
    .rd0_o(w_rd0), .a1_i(a1), .rd1_o(w_rd1), .busy_o(w_busy));
  ram_dp_be #(.ReadLatency(0), .WriteFirst(0), .ClearOnReset(1)) u_z (
    .clk_i(clk), .rst_i(rst), .a0_i(a0), .we0_i(we0), .be0_i(be0), .wd0_i(wd0),
    .rd0_o(z_rd0), .a1_i(a1), .rd1_o(z_rd1), .busy_o(z_busy));
  ram_dp_be #(.ReadLatency(1), .WriteFirst(0), .ClearOnReset(0)) u_n (
    .clk_i(clk), .rst_i(rst), .a0_i(a0), .we0_i(we0), .be0_i(be0), .wd0_i(wd0),
    .rd0_o(n_rd0), .a1_i(a1), .rd1_o(n_rd1), .busy_o(n_busy));
  function automatic logic [31:0] obs(int sel);
    case (sel)
      0: return d_rd0;
      1: return d_rd1;
      2: return {31'd0, d_busy};
      3: return w_rd1;
      4: return z_rd0;
      5: return z_rd1;
      6: return {31'd0, n_busy};
      7: return n_rd0;
      8: return w_rd0;
      default: return {31'd0, z_busy ^ w_busy};
    endcase
  endfunction
  task automatic chk(int d, int sel, logic [31:0] v, string nm);
    q.push_back('{d, sel, v, nm});
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due == cyc) begin
        tests++;
        if (obs(q[i].sel) !== q[i].v) begin
          fails++;
          $display("FAIL %s: cycle %0d got %h expected %h", q[i].nm, cyc, obs(q[i].sel), q[i].v);
        end
        q.delete(i);
      end
    end
  end
  initial begin
    rst = 1; we0 = 0; be0 = 0; wd0 = 0; a0 = 0; a1 = 0;
    chk(1, 2, 1, "rst_busy");
    chk(1, 0, 0, "rst_rd0");
    chk(1, 6, 1, "cor0_rst_busy");
    chk(1, 9, 0, "busy_agree");
    step();
    tests++;
    if (d_busy !== 1'b1) begin
      fails++;
      $display("FAIL inl_rst_busy: got %b", d_busy);
    end
    step(); rst = 0;
    #1;
    tests++;
    if ({d_busy, n_busy} !== 2'b10) begin
      fails++;
      $display("FAIL inl_release: got %b%b", d_busy, n_busy);
    end
    chk(2, 6, 0, "cor0_busy_release");
    chk(2, 7, 0, "cor0_rd0_reset");
    chk(2, 2, 1, "clear_busy_start");
    chk(1025, 2, 1, "clear_busy_last");
    chk(1026, 2, 0, "clear_busy_done");
    repeat (1024) step();
    a0 = 0;    chk(cyc + 1, 0, 0, "clear_a0"); step();
    a0 = 512;  chk(cyc + 1, 0, 0, "clear_a512"); step();
    a0 = 1023; chk(cyc + 1, 0, 0, "clear_a1023"); step();
    a0 = 5; we0 = 1; be0 = 4'hF; wd0 = 32'hDEAD_BEEF;
    chk(cyc + 1, 0, 0, "rf_p0_old");
    chk(cyc, 4, 0, "async_old");
    step();
    wd0 = 32'h1122_3344; be0 = 4'b0101;
    chk(cyc + 1, 0, 32'hDEAD_BEEF, "rf_p0_prev");
    chk(cyc + 1, 8, 32'hDE22_BE44, "wf_p0_merge");
    chk(cyc, 4, 32'hDEAD_BEEF, "async_new");
    step();
    we0 = 0;
    #1;
    tests++;
    if (z_rd0 !== 32'hDE22_BE44) begin
      fails++;
      $display("FAIL inl_async_merge: got %h", z_rd0);
    end
    chk(cyc + 1, 0, 32'hDE22_BE44, "be_merge");
    chk(cyc + 1, 7, 32'hDE22_BE44, "cor0_merge");
    chk(cyc, 4, 32'hDE22_BE44, "async_merge");
    step();
    a0 = 7; a1 = 7; we0 = 1; be0 = 4'hF; wd0 = 32'hAAAA_5555;
    chk(cyc + 1, 1, 0, "rf_collide");
    chk(cyc + 1, 3, 32'hAAAA_5555, "wf_collide");
    chk(cyc, 5, 0, "async_rd1_old");
    step();
    we0 = 0;
    chk(cyc + 1, 1, 32'hAAAA_5555, "rf_after");
    chk(cyc, 5, 32'hAAAA_5555, "async_rd1_new");
    step();
    a0 = 3; we0 = 1; be0 = 4'hF; wd0 = 32'h1234_5678; a1 = 5;
    chk(cyc, 4, 0, "rl0_pre_edge");
    chk(cyc, 5, 32'hDE22_BE44, "rl0_rd1_a5");
    step();
    we0 = 0; a1 = 7;
    chk(cyc, 4, 32'h1234_5678, "rl0_post_edge");
    chk(cyc, 5, 32'hAAAA_5555, "rl0_rd1_a7");
    step();
    a0 = 5; we0 = 1; be0 = 4'b1000; wd0 = 32'hFF00_0000; step();
    a0 = 3; be0 = 4'b0000; wd0 = 32'h0; step();
    we0 = 0; wd0 = 32'hFFFF_FFFF; a0 = 5;
    chk(cyc + 1, 0, 32'hFF22_BE44, "byte_keep");
    chk(cyc + 1, 7, 32'hFF22_BE44, "cor0_byte_keep");
    step();
    a0 = 3;
    chk(cyc + 1, 0, 32'h1234_5678, "be0_nop");
    chk(cyc + 1, 7, 32'h1234_5678, "cor0_be0_nop");
    step();
    a0 = 4; a1 = 6;
    chk(cyc + 1, 0, 0, "neighbor_a4");
    chk(cyc + 1, 1, 0, "neighbor_a6");
    step();
    rst = 1; chk(cyc, 2, 1, "rst2_busy"); step(); rst = 0;
    repeat (300) step();
    rst = 1; chk(cyc, 6, 1, "cor0_rst3_busy"); step(); rst = 0;
    s = cyc;
    chk(s, 6, 0, "cor0_rst3_release");
    chk(s + 1023, 2, 1, "restart_busy");
    chk(s + 1024, 2, 0, "restart_done");
    repeat (100) step();
    a0 = 5;
    chk(cyc + 1, 0, 0, "busy_rd0_forced");
    chk(cyc, 4, 0, "busy_async_forced");
    step();
    a0 = 9; we0 = 1; be0 = 4'hF; wd0 = 32'hFFFF_FFFF; step();
    we0 = 0;
    while (cyc < s + 1024) step();
    a0 = 9; a1 = 5;
    chk(cyc + 1, 0, 0, "busy_we_ignored");
    chk(cyc + 1, 1, 0, "reclear_a5");
    step();
    repeat (3) step();
    tests++;
    if (d_busy !== 1'b0) begin
      fails++;
      $display("FAIL inl_clear_done: got %b", d_busy);
    end
    foreach (q[i]) begin
      tests++;
      fails++;
      $display("FAIL %s: never sampled, expected %h at cycle %0d", q[i].nm, q[i].v, q[i].due);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ram_dp_be.md
Name: ram_dp_be

Overview:
- Parametrised RAM for the processor data/instruction memory path.
- Port 0 is read/write with per-byte write enables. Port 1 is read-only.
- Read latency is selectable: asynchronous or registered. Collision policy is selectable.
- A hardware clear FSM zeroes every position after reset and reports busy while it runs.

Parameters:
- DataWidth, 32, word width in bits; must be a multiple of 8; NBytes = DataWidth/8.
- NPos, 1024, number of words; power of two, at least 4; NPosWidth = $clog2(NPos).
- ReadLatency, 1, 0 = asynchronous read; 1 = registered read.
- WriteFirst, 0, same-address collision when ReadLatency=1: 0 = read-first (old data), 1 = write-first (new merged data).
- ClearOnReset, 1, 1 = zero the whole array after reset; 0 = no clear, contents undefined.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- a0_i  in  NPosWidth  port 0 word address.
- we0_i  in  1  port 0 write enable.
- be0_i  in  NBytes  port 0 byte enables; bit k covers bits [8k+7:8k].
- wd0_i  in  DataWidth  port 0 write data.
- rd0_o  out  DataWidth  port 0 read data.
- a1_i  in  NPosWidth  port 1 word address.
- rd1_o  out  DataWidth  port 1 read data.
- busy_o  out  1  high while reset or clear is in progress; all accesses are ignored.

Behaviour:
- States: CLEAR and IDLE. Clear counter cnt is NPosWidth bits wide.
- Reset (rst_i sampled high at an edge):
  - cnt <= 0.
  - State <= CLEAR if ClearOnReset=1, else IDLE.
  - Registered rd0_o/rd1_o <= 0.
  - No array write occurs in a reset cycle.
- A reset asserted mid-clear restarts the clear from address 0.
- busy_o = rst_i OR (state==CLEAR). It is combinational on rst_i, so busy_o is high in the reset cycle itself.
- CLEAR, each cycle with rst_i low:
  - mem[cnt] <= 0 and cnt <= cnt+1.
  - After cnt==NPos-1 is written, state <= IDLE.
  - The clear takes exactly NPos cycles after rst_i falls, so busy_o falls NPos cycles after the first low-reset edge.
- While busy_o=1:
  - we0_i is ignored.
  - rd0_o and rd1_o are forced to 0: combinationally when ReadLatency=0, registered to 0 when ReadLatency=1.
- IDLE write: if we0_i=1 at an edge, for each k with be0_i[k]=1, mem[a0_i] byte k <= wd0_i byte k. Bytes with be0_i[k]=0 are unchanged.
- we0_i=1 with be0_i=0 is legal and causes no change.
- we0_i=0: no position changes.
- ReadLatency=0:
  - rd0_o = mem[a0_i] and rd1_o = mem[a1_i], combinational.
  - A write becomes visible the cycle after its edge. WriteFirst has no effect.
- ReadLatency=1:
  - At each edge, rd0_o <= mem[a0_i] and rd1_o <= mem[a1_i]. Latency is 1 cycle.
- Collision (ReadLatency=1, write at the edge, read address == a0_i):
  - WriteFirst=0: the read returns the pre-write word.
  - WriteFirst=1: the read returns the byte-merged post-write word.
  - The rule applies to port 0 and to port 1 identically.
- Addresses cover the full power-of-two range, so there is no out-of-range case.
- Simultaneous reads from both ports are always allowed.

Test Plan:
1. Default params. Pulse rst_i for 2 cycles, then release. Expect busy_o high for the 2 reset cycles plus exactly 1024 cycles, then low. After that, rd0_o reads 0x00000000 at addresses 0, 512 and 1023.
2. Write 0xDEADBEEF to address 5 with be0_i=4'hF. Then write 0x11223344 to address 5 with be0_i=4'b0101. Read address 5: rd0_o = 0xDE22BE44, valid one cycle after the address is presented.
3. WriteFirst=0. Write 0xAAAA5555 (be0_i=4'hF) to address 7, which holds 0x0. In the same cycle, a1_i=7. Expect rd1_o=0x0 next cycle and 0xAAAA5555 the cycle after. Repeat with WriteFirst=1: rd1_o=0xAAAA5555 on the first cycle.
4. ReadLatency=0. Write 0x12345678 to address 3 and hold a0_i=3. rd0_o shows the old value before the edge and 0x12345678 after it. rd1_o tracks a1_i combinationally.
5. Assert rst_i at clear cycle 300 of 1024. Expect the clear to restart: busy_o stays high 1024 cycles after the second reset release. A we0_i pulse during busy leaves the target address at 0.
6. ClearOnReset=0. After reset, expect busy_o low the cycle after rst_i falls. For a position that is neither written nor selected on either read port, assert mem[i]==$past(mem[i]) every cycle with we0_i=0, and likewise for unenabled bytes.
